// File: rtl/handshake_sched_pkg.sv
// Shared types and helpers for the handshake link scheduler.
package handshake_sched_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } sched_state_e;

    // Successor of idx in a ring of n entries; n need not be a power of two.
    function automatic int next_idx(input int idx, input int n);
        return (idx == n - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/handshake_rr_pick.sv
// Rotating first-one finder: first set request at or after prio_i, wrapping at NumReq.
module handshake_rr_pick #(
    parameter int  NumReq = 4,
    localparam int IdxW   = $clog2(NumReq)
) (
    input  logic [NumReq-1:0] req_i,
    input  logic [IdxW-1:0]   prio_i,
    output logic [IdxW-1:0]   idx_o,
    output logic              valid_o
);

    logic [IdxW-1:0]   cand [NumReq];
    logic [NumReq-1:0] hit;

    // cand[gi] is the requester examined at rotation distance gi from prio_i.
    for (genvar gi = 0; gi < NumReq; gi++) begin : g_rot
        logic [IdxW:0] sum;
        assign sum      = {1'b0, prio_i} + (IdxW+1)'(gi);
        assign cand[gi] = (sum >= (IdxW+1)'(NumReq)) ? IdxW'(sum - (IdxW+1)'(NumReq))
                                                     : sum[IdxW-1:0];
        assign hit[gi]  = req_i[cand[gi]];
    end

    always_comb begin
        idx_o   = '0;
        valid_o = |hit;
        for (int k = NumReq - 1; k >= 0; k--) begin
            if (hit[k]) begin
                idx_o = cand[k];
            end
        end
    end

endmodule

// File: rtl/handshake_link_scheduler.sv
// Round-robin scheduler sharing one single-outstanding 4-phase link among NumReq requesters;
// the grant is held while the link has not yet accepted, so the crossing sees stable valid/data.
module handshake_link_scheduler
    import handshake_sched_pkg::*;
#(
    parameter int  NumReq   = 4,
    parameter int  MaxBurst = 1,
    parameter type data_t   = logic [31:0],
    localparam int IdxW     = $clog2(NumReq)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [NumReq-1:0]     req_valid_i,
    input  data_t [NumReq-1:0]    req_data_i,
    output logic [NumReq-1:0]     req_ready_o,
    output logic                  link_valid_o,
    output data_t                 link_data_o,
    input  logic                  link_ready_i,
    output logic [IdxW-1:0]       gnt_idx_o,
    output logic                  locked_o
);

    localparam int DataW  = $bits(data_t);
    localparam int BurstW = (MaxBurst > 1) ? $clog2(MaxBurst) : 1;

    sched_state_e      state_q, state_d;
    logic [IdxW-1:0]   prio_q, prio_d;
    logic [IdxW-1:0]   gnt_q, gnt_d;
    logic [BurstW-1:0] burst_q, burst_d;

    logic [IdxW-1:0]   pick_idx;
    logic              pick_valid;
    logic [IdxW-1:0]   gnt;
    logic              link_valid;
    logic              fire;
    logic [DataW-1:0]  masked [NumReq];
    logic [DataW-1:0]  link_data;

    handshake_rr_pick #(
        .NumReq (NumReq)
    ) u_pick (
        .req_i   (req_valid_i),
        .prio_i  (prio_q),
        .idx_o   (pick_idx),
        .valid_o (pick_valid)
    );

    always_comb begin
        state_d    = state_q;
        prio_d     = prio_q;
        gnt_d      = gnt_q;
        burst_d    = burst_q;
        gnt        = pick_idx;
        link_valid = pick_valid;
        locked_o   = 1'b0;

        if (state_q == LOCKED) begin
            gnt        = gnt_q;
            link_valid = req_valid_i[gnt_q];
            locked_o   = 1'b1;
        end

        fire = link_valid && link_ready_i;

        case (state_q)
            IDLE: begin
                if (link_valid && !link_ready_i) begin
                    gnt_d   = gnt;
                    state_d = LOCKED;
                end
            end
            LOCKED: begin
                // A dropped valid abandons the grant without touching priority.
                if (fire || !link_valid) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (fire) begin
            if (gnt == prio_q && int'(burst_q) + 1 < MaxBurst) begin
                burst_d = burst_q + BurstW'(1);
            end else if (gnt == prio_q || MaxBurst == 1) begin
                prio_d  = IdxW'(next_idx(int'(gnt), NumReq));
                burst_d = '0;
            end else begin
                prio_d  = gnt;
                burst_d = BurstW'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            prio_q  <= '0;
            gnt_q   <= '0;
            burst_q <= '0;
        end else begin
            state_q <= state_d;
            prio_q  <= prio_d;
            gnt_q   <= gnt_d;
            burst_q <= burst_d;
        end
    end

    for (genvar gi = 0; gi < NumReq; gi++) begin : g_lane
        assign req_ready_o[gi] = fire && (gnt == IdxW'(gi));
        assign masked[gi]      = {DataW{link_valid && (gnt == IdxW'(gi))}} & DataW'(req_data_i[gi]);
    end

    // AND-OR mux: at most one lane is unmasked, so no priority chain is needed.
    always_comb begin
        link_data = '0;
        for (int k = 0; k < NumReq; k++) begin
            link_data = link_data | masked[k];
        end
    end

    assign link_data_o  = data_t'(link_data);
    assign link_valid_o = link_valid;
    assign gnt_idx_o    = gnt;

`ifndef SYNTHESIS
    a_ready_onehot: assert property (@(posedge clk_i) disable iff (rst_i)
        $onehot0(req_ready_o))
        else $error("req_ready_o has more than one bit set");

    a_link_hold: assert property (@(posedge clk_i) disable iff (rst_i)
        (link_valid_o && !link_ready_i) |=> link_valid_o)
        else $error("link_valid_o dropped before link_ready_i");

    for (genvar gi = 0; gi < NumReq; gi++) begin : g_chk
        a_valid_hold: assert property (@(posedge clk_i) disable iff (rst_i)
            (req_valid_i[gi] && !req_ready_o[gi]) |=> req_valid_i[gi])
            else $error("requester %0d dropped valid before ready", gi);

        a_data_hold: assert property (@(posedge clk_i) disable iff (rst_i)
            (req_valid_i[gi] && !req_ready_o[gi]) |=> $stable(req_data_i[gi]))
            else $error("requester %0d changed data before ready", gi);
    end
`endif

endmodule

// File: tb/tb_handshake_link_scheduler.sv
// Bench for handshake_link_scheduler: hand vector table, corner sequences and randomized
// traffic on a MaxBurst=1 and a MaxBurst=3 instance, both checked against a rule-level model.
module tb_handshake_link_scheduler;

    localparam int N = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst    [2];
    logic [N-1:0]      valid  [2];
    logic [N-1:0][31:0] data  [2];
    logic              lrdy   [2];
    logic [N-1:0]      rdy_o  [2];
    logic              lv_o   [2];
    logic [31:0]       ld_o   [2];
    logic [1:0]        gi_o   [2];
    logic              lk_o   [2];

    handshake_link_scheduler #(.NumReq(N), .MaxBurst(1), .data_t(logic [31:0])) u_dut_b1 (
        .clk_i(clk), .rst_i(rst[0]), .req_valid_i(valid[0]), .req_data_i(data[0]),
        .req_ready_o(rdy_o[0]), .link_valid_o(lv_o[0]), .link_data_o(ld_o[0]),
        .link_ready_i(lrdy[0]), .gnt_idx_o(gi_o[0]), .locked_o(lk_o[0])
    );

    handshake_link_scheduler #(.NumReq(N), .MaxBurst(3), .data_t(logic [31:0])) u_dut_b3 (
        .clk_i(clk), .rst_i(rst[1]), .req_valid_i(valid[1]), .req_data_i(data[1]),
        .req_ready_o(rdy_o[1]), .link_valid_o(lv_o[1]), .link_data_o(ld_o[1]),
        .link_ready_i(lrdy[1]), .gnt_idx_o(gi_o[1]), .locked_o(lk_o[1])
    );

    int checks   = 0;
    int failures = 0;

    // Reference model state: who holds the link, and where round-robin priority stands.
    int     mb       [2] = '{1, 3};
    int     m_prio   [2];
    int     m_burst  [2];
    int     m_lg     [2];
    bit     m_locked [2];
    logic [N-1:0] served [2];

    typedef struct {
        logic         lv;
        logic [1:0]   g;
        logic [N-1:0] rdy;
        logic [31:0]  d;
        logic         lk;
    } exp_t;

    typedef struct {
        logic [3:0] v;
        logic       r;
        logic       lv;
        logic [1:0] g;
        logic [3:0] rdy;
        logic       lk;
    } vec_t;

    vec_t tbl [22];

    task automatic chk(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s dut%0d: got %h expected %h", name, d, act, exp);
        end
    endtask

    function automatic void model_reset(input int d);
        m_prio[d]   = 0;
        m_burst[d]  = 0;
        m_lg[d]     = 0;
        m_locked[d] = 0;
    endfunction

    function automatic exp_t model_out(input int d);
        exp_t e;
        e.lv  = 1'b0;
        e.g   = 2'd0;
        e.rdy = '0;
        e.lk  = m_locked[d];
        if (m_locked[d]) begin
            e.g  = 2'(m_lg[d]);
            e.lv = valid[d][e.g];
        end else begin
            e.lv = |valid[d];
            for (int k = N - 1; k >= 0; k--) begin
                int j = (m_prio[d] + k) % N;
                if (valid[d][2'(j)]) e.g = 2'(j);
            end
        end
        e.d = e.lv ? data[d][e.g] : 32'd0;
        if (e.lv && lrdy[d]) e.rdy[e.g] = 1'b1;
        return e;
    endfunction

    function automatic void model_update(input int d, input exp_t e);
        int g = int'(e.g);
        if (rst[d]) begin
            model_reset(d);
        end else if (e.lv && lrdy[d]) begin
            if (g == m_prio[d] && m_burst[d] + 1 < mb[d]) begin
                m_burst[d]++;
            end else if (g == m_prio[d] || mb[d] == 1) begin
                m_prio[d]  = (g + 1) % N;
                m_burst[d] = 0;
            end else begin
                m_prio[d]  = g;
                m_burst[d] = 1;
            end
            m_locked[d] = 0;
        end else if (m_locked[d]) begin
            if (!valid[d][2'(m_lg[d])]) m_locked[d] = 0;
        end else if (e.lv) begin
            m_locked[d] = 1;
            m_lg[d]     = g;
        end
    endfunction

    // Called at a negedge: compare both DUTs with the model, then advance to just after posedge.
    task automatic tick();
        exp_t e;
        for (int d = 0; d < 2; d++) begin
            e = model_out(d);
            if (!rst[d]) begin
                chk("link_valid", d, 32'(lv_o[d]), 32'(e.lv));
                chk("gnt_idx",    d, 32'(gi_o[d]), 32'(e.g));
                chk("req_ready",  d, 32'(rdy_o[d]), 32'(e.rdy));
                chk("link_data",  d, ld_o[d], e.d);
                chk("locked",     d, 32'(lk_o[d]), 32'(e.lk));
            end
            served[d] = e.rdy;
            model_update(d, e);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        tbl[0]  = '{4'b0000, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b0};
        tbl[1]  = '{4'b1111, 1'b1, 1'b1, 2'd0, 4'b0001, 1'b0};
        tbl[2]  = '{4'b1111, 1'b1, 1'b1, 2'd1, 4'b0010, 1'b0};
        tbl[3]  = '{4'b1111, 1'b1, 1'b1, 2'd2, 4'b0100, 1'b0};
        tbl[4]  = '{4'b1111, 1'b1, 1'b1, 2'd3, 4'b1000, 1'b0};
        tbl[5]  = '{4'b1111, 1'b1, 1'b1, 2'd0, 4'b0001, 1'b0};
        tbl[6]  = '{4'b1110, 1'b1, 1'b1, 2'd1, 4'b0010, 1'b0};
        tbl[7]  = '{4'b1100, 1'b1, 1'b1, 2'd2, 4'b0100, 1'b0};
        tbl[8]  = '{4'b1000, 1'b1, 1'b1, 2'd3, 4'b1000, 1'b0};
        tbl[9]  = '{4'b0000, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b0};
        tbl[10] = '{4'b0110, 1'b0, 1'b1, 2'd1, 4'b0000, 1'b0};
        tbl[11] = '{4'b0110, 1'b0, 1'b1, 2'd1, 4'b0000, 1'b1};
        tbl[12] = '{4'b0110, 1'b0, 1'b1, 2'd1, 4'b0000, 1'b1};
        tbl[13] = '{4'b0110, 1'b0, 1'b1, 2'd1, 4'b0000, 1'b1};
        tbl[14] = '{4'b0110, 1'b0, 1'b1, 2'd1, 4'b0000, 1'b1};
        tbl[15] = '{4'b0110, 1'b1, 1'b1, 2'd1, 4'b0010, 1'b1};
        tbl[16] = '{4'b0100, 1'b1, 1'b1, 2'd2, 4'b0100, 1'b0};
        tbl[17] = '{4'b1000, 1'b1, 1'b1, 2'd3, 4'b1000, 1'b0};
        tbl[18] = '{4'b1001, 1'b0, 1'b1, 2'd0, 4'b0000, 1'b0};
        tbl[19] = '{4'b1001, 1'b1, 1'b1, 2'd0, 4'b0001, 1'b1};
        tbl[20] = '{4'b1000, 1'b1, 1'b1, 2'd3, 4'b1000, 1'b0};
        tbl[21] = '{4'b0000, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b0};

        for (int d = 0; d < 2; d++) begin
            rst[d]    = 1'b1;
            valid[d]  = '0;
            lrdy[d]   = 1'b0;
            served[d] = '0;
            for (int i = 0; i < N; i++) data[d][i] = 32'hA5A5_0000 + 32'(i) + 32'(d) * 32'h100;
            model_reset(d);
        end
        @(posedge clk);
        #1;
        @(negedge clk);
        tick();
        rst[0] = 1'b0;
        rst[1] = 1'b0;

        // Vector table on the MaxBurst=1 instance; row 0 is the post-reset idle state.
        for (int r = 0; r < 22; r++) begin
            logic [31:0] exp_d;
            valid[0] = tbl[r].v;
            lrdy[0]  = tbl[r].r;
            @(negedge clk);
            exp_d = tbl[r].lv ? data[0][tbl[r].g] : 32'd0;
            chk($sformatf("row%0d_lv", r),  0, 32'(lv_o[0]),  32'(tbl[r].lv));
            chk($sformatf("row%0d_gnt", r), 0, 32'(gi_o[0]),  32'(tbl[r].g));
            chk($sformatf("row%0d_rdy", r), 0, 32'(rdy_o[0]), 32'(tbl[r].rdy));
            chk($sformatf("row%0d_lk", r),  0, 32'(lk_o[0]),  32'(tbl[r].lk));
            chk($sformatf("row%0d_dat", r), 0, ld_o[0], exp_d);
            tick();
        end

        // MaxBurst=3: requester 0 takes three fires, then 2 takes three, then back to 0.
        begin
            int gl [7] = '{0, 0, 0, 2, 2, 2, 0};
            valid[1] = 4'b0101;
            lrdy[1]  = 1'b1;
            for (int k = 0; k < 7; k++) begin
                logic [3:0] er;
                er = 4'b0001 << gl[k];
                @(negedge clk);
                chk($sformatf("burst%0d_gnt", k), 1, 32'(gi_o[1]),  32'(gl[k]));
                chk($sformatf("burst%0d_rdy", k), 1, 32'(rdy_o[1]), 32'(er));
                tick();
            end
        end

        // Reset while LOCKED on requester 1, after priority was moved away from 0.
        valid[0] = 4'b0100; lrdy[0] = 1'b1;
        @(negedge clk);
        chk("pre_gnt2", 0, 32'(gi_o[0]), 32'd2);
        tick();
        valid[0] = 4'b0010; lrdy[0] = 1'b0;
        @(negedge clk);
        chk("lock_gnt1", 0, 32'(gi_o[0]), 32'd1);
        tick();
        @(negedge clk);
        chk("locked_hi", 0, 32'(lk_o[0]), 32'd1);
        tick();
        rst[0] = 1'b1;
        @(negedge clk);
        tick();
        rst[0] = 1'b0; valid[0] = 4'b0000;
        @(negedge clk);
        chk("rst_lv",  0, 32'(lv_o[0]),  32'd0);
        chk("rst_rdy", 0, 32'(rdy_o[0]), 32'd0);
        chk("rst_lk",  0, 32'(lk_o[0]),  32'd0);
        chk("rst_gnt", 0, 32'(gi_o[0]),  32'd0);
        tick();
        valid[0] = 4'b1111; lrdy[0] = 1'b1;
        @(negedge clk);
        chk("rst_prio0", 0, 32'(gi_o[0]), 32'd0);
        tick();

        // Randomized traffic; requesters hold valid/data until served, resets are occasional.
        for (int c = 0; c < 400; c++) begin
            for (int d = 0; d < 2; d++) begin
                rst[d]  = ($urandom_range(0, 39) == 0);
                lrdy[d] = ($urandom_range(0, 2) != 0);
                for (int i = 0; i < N; i++) begin
                    if (!valid[d][i] || served[d][i]) begin
                        valid[d][i] = ($urandom_range(0, 1) == 1);
                        data[d][i]  = $urandom;
                    end
                end
            end
            @(negedge clk);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
